// File: rtl/song_pkg.sv
// Shared widths, ROM entry field positions and FSM encoding for the song sequencer.
// Each ROM word: [15] reserved, [14:9] note, [8:3] duration, [2:0] reserved.
package song_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;

    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;

    localparam logic [DUR_W-1:0]  END_DUR   = '0;
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;
    localparam logic [IDX_W-1:0]  LAST_IDX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        PLAY,
        DONE
    } state_t;

endpackage

// File: rtl/song_reader_duration_timer.sv
// Loadable down-counter that times one note in beat ticks.
// expire fires on the counted beat that arrives while the count is 1.
module duration_timer
    import song_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [DUR_W-1:0] count;

    // clear (restart) wins over load, load wins over counting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - DUR_W'(1);
        end
    end

    assign expire = en && (count == DUR_W'(1));

endmodule

// File: rtl/song_reader.sv
// Sequencer behind song_rom: walks one song slot, decodes note/duration entries
// and holds each note for its duration in counted beats.
module song_reader
    import song_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    play,
    input  logic                    restart,
    input  logic [SONG_W-1:0]       song,
    input  logic                    beat,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [15:0]             rom_dout,
    output logic [NOTE_W-1:0]       note,
    output logic                    note_valid,
    output logic                    new_note,
    output logic                    song_done,
    output state_t                  dbg_state
);

    state_t              state;
    state_t              state_nxt;
    logic [SONG_W-1:0]   song_r;
    logic [IDX_W-1:0]    idx;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                is_end;
    logic                do_restart;
    logic                start;
    logic                advance;
    logic                load_en;
    logic                count_en;
    logic                expire;
    logic                unused_rom_bits;

    assign rom_note        = rom_dout[NOTE_MSB:NOTE_LSB];
    assign rom_dur         = rom_dout[DUR_MSB:DUR_LSB];
    assign is_end          = (rom_dur == END_DUR);
    assign unused_rom_bits = ^{rom_dout[15], rom_dout[2:0]};
    assign do_restart      = restart && (state != IDLE);
    assign rom_addr        = {song_r, idx};
    assign dbg_state       = state;

    duration_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (do_restart),
        .load     (load_en),
        .load_val (rom_dur),
        .en       (count_en),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (do_restart) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                IDLE: if (play) state_nxt = ADDR;
                ADDR: state_nxt = READ;
                READ: state_nxt = is_end ? DONE : PLAY;
                PLAY: if (expire) state_nxt = (idx == LAST_IDX) ? DONE : ADDR;
                DONE: if (!play) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Restart pre-empts any beat or load in the same cycle.
    always_comb begin
        note_valid = (state == PLAY) && play;
        start      = (state == IDLE) && play;
        load_en    = (state == READ) && !is_end && !do_restart;
        count_en   = (state == PLAY) && beat && play && !do_restart;
        advance    = (state == PLAY) && expire && (idx != LAST_IDX) && !do_restart;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            song_r    <= '0;
            idx       <= '0;
            note      <= REST_NOTE;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            new_note  <= load_en;
            song_done <= (state_nxt == DONE) && (state != DONE);

            if (do_restart || start) begin
                song_r <= song;
                idx    <= '0;
            end else if (advance) begin
                idx <= idx + IDX_W'(1);
            end

            // note holds through ADDR/READ of the next entry; cleared on restart or finish
            if (do_restart || ((state_nxt == DONE) && (state != DONE))) begin
                note <= REST_NOTE;
            end else if (load_en) begin
                note <= rom_note;
            end
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: a behavioural song ROM plus a note/duration scoreboard built
// straight from the ROM contents, driven with random beats, pauses and song changes.
module tb_song_reader;
    import song_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        play;
    logic        restart;
    logic [1:0]  song;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [15:0] rom_dout;
    logic [5:0]  note;
    logic        note_valid;
    logic        new_note;
    logic        song_done;
    state_t      dbg_state;

    logic [15:0] rom_mem [128];

    int checks = 0;
    int errors = 0;

    song_reader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .play       (play),
        .restart    (restart),
        .song       (song),
        .beat       (beat),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .note       (note),
        .note_valid (note_valid),
        .new_note   (new_note),
        .song_done  (song_done),
        .dbg_state  (dbg_state)
    );

    // clock / ROM model with one cycle read latency
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ent(input logic [5:0] n, input logic [5:0] d);
        return {1'($urandom), n, d, 3'($urandom)};
    endfunction

    // Idles with random (to-be-dropped) beats until new_note or song_done shows up.
    task automatic wait_for(input bit want_done, input int s, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (want_done ? song_done : new_note) begin
                seen = 1'b1;
                break;
            end
            beat = 1'($urandom_range(0, 1));
            if (k > 0) song = 2'($urandom_range(0, 3));
            cyc();
            chk("slot", 32'(rom_addr[6:5]), s);
        end
        beat = 1'b0;
    endtask

    // Scoreboard: expected notes come from the ROM slot up to the end marker or entry 31.
    task automatic play_song(input int s, input bit pauses);
        logic [11:0] exp_q[$];
        logic [15:0] e;
        logic [5:0]  en;
        logic [5:0]  ed;
        int          last_idx;
        int          idx;
        int          left;
        bit          seen;
        last_idx = 31;
        for (int i = 0; i < 32; i++) begin
            e = rom_mem[s*32+i];
            if (e[8:3] == 6'd0) begin
                last_idx = i;
                break;
            end
            exp_q.push_back({e[14:9], e[8:3]});
        end
        song = 2'(s);
        play = 1'b1;
        beat = 1'b0;
        idx  = 0;
        while (exp_q.size() > 0) begin
            {en, ed} = exp_q.pop_front();
            wait_for(1'b0, s, seen);
            chk("new_note_seen", 32'(seen), 1);
            chk("load_note", 32'(note), 32'(en));
            chk("load_valid", 32'(note_valid), 1);
            chk("load_addr", 32'(rom_addr), s*32+idx);
            left = int'(ed);
            while (left > 0) begin
                if (pauses && ($urandom_range(0, 3) == 0)) begin
                    play = 1'b0;
                    beat = 1'($urandom_range(0, 1));
                    cyc();
                    chk("pause_valid", 32'(note_valid), 0);
                    chk("pause_note", 32'(note), 32'(en));
                    play = 1'b1;
                end else begin
                    beat = 1'($urandom_range(0, 1));
                    cyc();
                    if (beat) left--;
                    if (left > 0) begin
                        chk("hold_valid", 32'(note_valid), 1);
                        chk("hold_note", 32'(note), 32'(en));
                    end else begin
                        chk("gap_valid", 32'(note_valid), 0);
                        chk("gap_note", 32'(note), (idx == 31) ? 0 : 32'(en));
                    end
                    chk("new_note_pulse", 32'(new_note), 0);
                end
            end
            beat = 1'b0;
            idx++;
        end
        wait_for(1'b1, s, seen);
        chk("song_done_seen", 32'(seen), 1);
        chk("done_note", 32'(note), 0);
        chk("done_valid", 32'(note_valid), 0);
        chk("done_addr", 32'(rom_addr), s*32+last_idx);
        beat = 1'($urandom_range(0, 1));
        cyc();
        chk("done_pulse", 32'(song_done), 0);
        chk("done_hold", 32'(dbg_state), 32'(DONE));
        beat = 1'b0;
        play = 1'b0;
        cyc();
        chk("back_idle", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        bit seen;
        int s;
        int endk;
        int left;

        reset_n = 1'b0;
        play    = 1'b0;
        restart = 1'b0;
        song    = 2'd0;
        beat    = 1'b0;

        for (int i = 0; i < 32; i++) begin
            if (i < 10)       rom_mem[i] = ent(6'($urandom_range(1, 63)), (i == 5) ? 6'd4 : 6'($urandom_range(1, 3)));
            else if (i == 10) rom_mem[i] = ent(6'($urandom_range(0, 63)), 6'd0);
            else              rom_mem[i] = ent(6'($urandom_range(0, 63)), 6'($urandom_range(1, 3)));
            rom_mem[32+i] = ent(6'($urandom_range(0, 63)), 6'($urandom_range(1, 3)));
            rom_mem[64+i] = ent(6'($urandom_range(0, 63)), 6'($urandom_range(1, 3)));
            rom_mem[96+i] = ent(6'($urandom_range(0, 63)), 6'd1);
        end
        rom_mem[32] = ent(6'd35, 6'd3);
        rom_mem[33] = ent(6'd42, 6'd2);
        rom_mem[34] = ent(6'd7, 6'd0);
        rom_mem[64] = ent(6'd20, 6'd3);
        rom_mem[65] = ent(6'd44, 6'd5);
        rom_mem[66] = ent(6'd0, 6'd10);
        rom_mem[67] = ent(6'd30, 6'd4);
        rom_mem[68] = ent(6'd9, 6'd0);

        // reset state
        cyc();
        cyc();
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_note", 32'(note), 0);
        chk("rst_valid", 32'(note_valid), 0);
        chk("rst_new_note", 32'(new_note), 0);
        chk("rst_done", 32'(song_done), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        cyc();

        play_song(1, 1'b0);
        play_song(3, 1'b0);
        play_song(2, 1'b1);
        play_song(0, 1'b1);

        // restart with a simultaneous beat at song 0 entry 5
        song = 2'd0;
        play = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_for(1'b0, 0, seen);
            chk("adv_seen", 32'(seen), 1);
            chk("adv_note", 32'(note), 32'(rom_mem[i][14:9]));
            left = int'(rom_mem[i][8:3]);
            repeat (left) begin
                beat = 1'b1;
                cyc();
            end
            beat = 1'b0;
        end
        wait_for(1'b0, 0, seen);
        chk("e5_seen", 32'(seen), 1);
        chk("e5_addr", 32'(rom_addr), 5);
        beat = 1'b1;
        cyc();
        restart = 1'b1;
        beat    = 1'b1;
        song    = 2'd2;
        cyc();
        restart = 1'b0;
        beat    = 1'b0;
        chk("rs_addr", 32'(rom_addr), 64);
        chk("rs_note", 32'(note), 0);
        chk("rs_valid", 32'(note_valid), 0);
        cyc();
        chk("rs_read_new_note", 32'(new_note), 0);
        cyc();
        chk("rs_new_note", 32'(new_note), 1);
        chk("rs_first_note", 32'(note), 20);
        beat = 1'b1;
        cyc();
        cyc();
        beat = 1'b0;
        chk("rs_still_first", 32'(rom_addr), 64);
        chk("rs_still_valid", 32'(note_valid), 1);
        beat = 1'b1;
        cyc();
        beat = 1'b0;
        chk("rs_next_addr", 32'(rom_addr), 65);
        cyc();
        cyc();
        chk("rs_second_note", 32'(note), 44);
        chk("rs_second_new", 32'(new_note), 1);
        beat = 1'b1;
        cyc();
        beat = 1'b0;

        // asynchronous reset mid-note
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_addr", 32'(rom_addr), 0);
        chk("arst_note", 32'(note), 0);
        chk("arst_valid", 32'(note_valid), 0);
        chk("arst_new_note", 32'(new_note), 0);
        chk("arst_done", 32'(song_done), 0);
        play = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            beat = 1'($urandom_range(0, 1));
            cyc();
            chk("post_rst_idle", 32'(dbg_state), 32'(IDLE));
            chk("post_rst_addr", 32'(rom_addr), 0);
        end
        beat    = 1'b0;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("idle_restart_ignored", 32'(dbg_state), 32'(IDLE));

        // random songs with random end positions
        for (int r = 0; r < 4; r++) begin
            s    = $urandom_range(0, 3);
            endk = $urandom_range(0, 32);
            for (int i = 0; i < 32; i++) begin
                rom_mem[s*32+i] = ent(6'($urandom_range(0, 63)), (i == endk) ? 6'd0 : 6'($urandom_range(1, 4)));
            end
            play_song(s, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Sequencer directly downstream of song_rom.
- Walks the 32-entry slot of the selected song, fetches each 16-bit entry and decodes note/duration.
- Drives the current note to the note player and holds it for `duration` beat ticks.
- Stops on the end marker (duration 0) or after the last entry of the slot; supports pause and restart.

Parameters:
- NOTE_W, 6, note field width (0 = rest)
- DUR_W, 6, duration field width in beat ticks (0 = end-of-song marker)
- SONG_W, 2, song select width; ROM address = {song, index}
- IDX_W, 5, entry index width within a song (32 entries per song)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- play  in  1  level; 1 = run, 0 = pause/stop
- restart  in  1  single-cycle pulse; restart the song from entry 0
- song  in  SONG_W  song select; sampled only on start/restart
- beat  in  1  single-cycle tick, one per duration unit
- rom_addr  out  SONG_W+IDX_W  registered address to song_rom
- rom_dout  in  16  song_rom data; [15] reserved, [14:9] note, [8:3] duration, [2:0] reserved
- note  out  NOTE_W  current note, 0 when not playing
- note_valid  out  1  high while a note is sounding (PLAY state and play=1)
- new_note  out  1  one-cycle pulse when a note is loaded
- song_done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, reset_n=0): state IDLE; song_r=0, idx=0, dur_left=0; rom_addr=0, note=0, note_valid=0, new_note=0, song_done=0. Reset mid-operation aborts immediately, no pulses.
- rom_addr is always {song_r, idx}, registered.
- ROM read latency is 1 cycle: address stable in ADDR, data valid in READ.
- States:
  - IDLE: if play=1, latch song_r<=song, idx<=0, go to ADDR.
  - ADDR: unconditional transition to READ.
  - READ: decode rom_dout.
    - duration==0: note<=0, go to DONE.
    - Otherwise: note<=rom_dout[14:9], dur_left<=rom_dout[8:3], new_note=1 for the next cycle, go to PLAY.
    - Entry to ADDR → new_note high is 2 cycles.
  - PLAY: beat counts only when play=1.
    - On a counted beat with dur_left>1: decrement dur_left.
    - On a counted beat with dur_left==1: if idx==31 go to DONE; else idx<=idx+1 and go to ADDR.
    - No wrap into the next song's slot.
  - DONE: note=0; song_done pulses on entry only. Stay in DONE while play=1; go to IDLE when play=0. Holding play does not loop the song.
- Outputs by state:
  - note_valid = (state==PLAY) && play.
  - note holds its value during ADDR/READ of the following entry; note_valid is low then, giving a 2-cycle gap between notes.
- Pause: play=0 in PLAY freezes dur_left and idx; note stays loaded and note_valid drops. Resumes exactly where it stopped.
- Beats arriving in IDLE, ADDR, READ or DONE are dropped, not counted.
- restart=1 in any state except IDLE: song_r<=song, idx<=0, dur_left<=0, note<=0, go to ADDR.
  - restart takes priority over a simultaneous beat; that beat is dropped.
  - restart in IDLE is ignored.
- A change on song outside start/restart has no effect on the song in progress.
- A note value of 0 is a rest: loaded and timed like a note, with note_valid high and note=0.
- Duration range is 1..63 beats.

Decomposition:
- Package song_pkg holds:
  - NOTE_W, DUR_W, SONG_W, IDX_W
  - field constants NOTE_MSB=14, NOTE_LSB=9, DUR_MSB=8, DUR_LSB=3
  - END_DUR=0, REST_NOTE=0
  - state enum {IDLE, ADDR, READ, PLAY, DONE}
- One sub-module, duration_timer: loadable DUR_W down-counter with a count-enable (beat && play), producing an `expire` flag when a counted beat arrives at a count of 1.
- The FSM, index counter and decode stay in song_reader.

Test Plan:
- Bench ROM song 1 = {n35 d3, n42 d2, end} (addr 32..34); play=1 with song=1 → rom_addr 32; new_note 2 cycles later with note=35; after 3 beats addr 33, note=42; after 2 beats the READ of addr 34 → song_done pulse, note=0; play=0 → IDLE.
- Note n30 d4 loaded; 2 beats, play=0, 5 beats, play=1, 2 beats → exactly 4 counted beats before advancing; note_valid low during the pause; note stays 30.
- Song 3 with all 32 entries duration 1; 32 beats → after idx 31 expires, DONE with rom_addr 127 last; never reads addr 0.
- In PLAY on song 0 idx 5: restart and beat in the same cycle with song=2 → rom_addr 64, dur_left not decremented, new_note 2 cycles later.
- reset_n low mid-PLAY (note=44) → all outputs 0 asynchronously; after release, IDLE until play=1.
- Entry with note 0, duration 10 → note_valid high, note=0 for 10 beats; beats during ADDR/READ are not counted.
